// File: rtl/collision_pkg.sv
// collision_pkg: sprite geometry, scanner FSM states, the hit-box type and
// the saturating subtract shared by the collision scanner.
package collision_pkg;

  // Coordinate width the box type is built for; edges carry two spare bits
  // so that x+offset never wraps.
  localparam int COORD_W = 10;
  localparam int EDGE_W  = COORD_W + 2;

  // Car sprite (player and car obstacles)
  localparam int CAR_W     = 60;
  localparam int CAR_H     = 100;
  localparam int CAR_OFF_L = 15;
  localparam int CAR_OFF_R = 5;
  localparam int CAR_OFF_F = 10;
  localparam int CAR_OFF_B = 5;

  // Police sprite
  localparam int POL_W     = 64;
  localparam int POL_H     = 100;
  localparam int POL_OFF_L = 5;
  localparam int POL_OFF_R = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [EDGE_W-1:0] left;
    logic [EDGE_W-1:0] right;
    logic [EDGE_W-1:0] top;
    logic [EDGE_W-1:0] bottom;
  } box_t;

  // a - b, clamped to zero instead of going negative
  function automatic logic [EDGE_W-1:0] sat_sub(input logic [EDGE_W-1:0] a,
                                                input logic [EDGE_W-1:0] b);
    logic [EDGE_W-1:0] res;
    if (a >= b) begin
      res = a - b;
    end else begin
      res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/collision_scanner_box_overlap.sv
// box_overlap: inclusive axis-aligned rectangle intersection. Touching edges
// and full containment both count as overlap.
module box_overlap
  import collision_pkg::*;
(
  input  box_t a,
  input  box_t b,
  output logic overlap
);

  assign overlap = (a.left <= b.right) && (b.left <= a.right) &&
                   (a.top <= b.bottom) && (b.top <= a.bottom);

endmodule

// File: rtl/collision_scanner.sv
// collision_scanner: snapshots player/obstacle positions on start, tests one
// obstacle per clock through a single shared box_overlap, then commits the
// per-obstacle hit vector with a one-cycle done pulse.
// Optional feature: define COLLIDE_PERSIST_EN to require PERSIST consecutive
// overlapping scans before an obstacle reports a hit.
// W must not exceed collision_pkg::COORD_W (edges are sized from it).
module collision_scanner
  import collision_pkg::*;
#(
  parameter int               N_OBS       = 5,
  parameter int               W           = COORD_W,
  parameter logic [N_OBS-1:0] POLICE_MASK = N_OBS'(5'b00011),
  parameter int               PERSIST     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W-1:0]       mycar_pos_x,
  input  logic [W-1:0]       mycar_pos_y,
  input  logic [N_OBS*W-1:0] obstacle_pos_x,
  input  logic [N_OBS*W-1:0] obstacle_pos_y,
  output logic               busy,
  output logic               done,
  output logic [N_OBS-1:0]   hit,
  output logic               any_hit
);

  localparam int               IDX_W    = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBS - 1);

  localparam logic [EDGE_W-1:0] K_CAR_L  = EDGE_W'(CAR_OFF_L);
  localparam logic [EDGE_W-1:0] K_CAR_R  = EDGE_W'(CAR_W - CAR_OFF_R);
  localparam logic [EDGE_W-1:0] K_CAR_F  = EDGE_W'(CAR_OFF_F);
  localparam logic [EDGE_W-1:0] K_CAR_BR = EDGE_W'(CAR_H - CAR_OFF_B);
  localparam logic [EDGE_W-1:0] K_CAR_B  = EDGE_W'(CAR_OFF_B);
  localparam logic [EDGE_W-1:0] K_CAR_H  = EDGE_W'(CAR_H);
  localparam logic [EDGE_W-1:0] K_POL_L  = EDGE_W'(POL_OFF_L);
  localparam logic [EDGE_W-1:0] K_POL_R  = EDGE_W'(POL_W - POL_OFF_R);
  localparam logic [EDGE_W-1:0] K_POL_H  = EDGE_W'(POL_H);

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       snap_mx;
  logic [W-1:0]       snap_my;
  logic [N_OBS*W-1:0] snap_ox;
  logic [N_OBS*W-1:0] snap_oy;
  logic [W-1:0]       obs_x [N_OBS];
  logic [W-1:0]       obs_y [N_OBS];
  logic [EDGE_W-1:0]  sel_x;
  logic [EDGE_W-1:0]  sel_y;
  logic               sel_police;
  box_t               player_box;
  box_t               obs_box;
  logic               overlap;
  logic [N_OBS-1:0]   shadow;
  logic [N_OBS-1:0]   scan_vec;
  logic [N_OBS-1:0]   filtered;
  logic               last_step;
  logic               busy_next;
  logic               done_next;

  // Unpack the snapshot so the shared comparator can be fed by index.
  for (genvar g = 0; g < N_OBS; g++) begin : g_unpack
    assign obs_x[g] = snap_ox[g*W +: W];
    assign obs_y[g] = snap_oy[g*W +: W];
  end

  assign sel_x      = EDGE_W'(obs_x[idx]);
  assign sel_y      = EDGE_W'(obs_y[idx]);
  assign sel_police = POLICE_MASK[idx];
  assign last_step  = (state == SCAN) && (idx == LAST_IDX);

  // Player hit box from the snapshotted top-left corner.
  always_comb begin
    player_box        = '0;
    player_box.left   = EDGE_W'(snap_mx) + K_CAR_L;
    player_box.right  = EDGE_W'(snap_mx) + K_CAR_R;
    player_box.top    = EDGE_W'(snap_my) + K_CAR_F;
    player_box.bottom = EDGE_W'(snap_my) + K_CAR_BR;
  end

  // Hit box of the obstacle under test; y is the sprite's bottom edge.
  always_comb begin
    obs_box = '0;
    if (sel_police) begin
      obs_box.left   = sel_x + K_POL_L;
      obs_box.right  = sel_x + K_POL_R;
      obs_box.top    = sat_sub(sel_y, K_POL_H);
      obs_box.bottom = sel_y;
    end else begin
      obs_box.left   = sel_x + K_CAR_L;
      obs_box.right  = sel_x + K_CAR_R;
      obs_box.top    = sat_sub(sel_y + K_CAR_F, K_CAR_H);
      obs_box.bottom = sat_sub(sel_y, K_CAR_B);
    end
  end

  box_overlap u_overlap (
    .a       (player_box),
    .b       (obs_box),
    .overlap (overlap)
  );

  // Shadow vector including the result being produced this cycle.
  always_comb begin
    scan_vec      = shadow;
    scan_vec[idx] = overlap;
  end

`ifdef COLLIDE_PERSIST_EN
  localparam logic [1:0] PERSIST_C = 2'(PERSIST);

  logic [1:0] cnt      [N_OBS];
  logic [1:0] cnt_next [N_OBS];

  // Saturating per-obstacle overlap streak; a hit needs a full streak.
  always_comb begin
    filtered = '0;
    for (int i = 0; i < N_OBS; i++) begin
      if (!scan_vec[i]) begin
        cnt_next[i] = 2'd0;
      end else if (cnt[i] == PERSIST_C) begin
        cnt_next[i] = cnt[i];
      end else begin
        cnt_next[i] = cnt[i] + 2'd1;
      end
      filtered[i] = (cnt_next[i] == PERSIST_C);
    end
  end

  // Streak counters advance only when a scan commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OBS; i++) cnt[i] <= 2'd0;
    end else if (last_step) begin
      for (int i = 0; i < N_OBS; i++) cnt[i] <= cnt_next[i];
    end
  end
`else
  assign filtered = scan_vec;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state; start is only honoured in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SCAN; else next_state = IDLE;
      SCAN:    if (idx == LAST_IDX) next_state = COMMIT; else next_state = SCAN;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs, registered below so busy/done are glitch-free.
  always_comb begin
    busy_next = (next_state != IDLE);
    done_next = (next_state == COMMIT);
  end

  // Snapshot, scan index and shadow vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      snap_mx <= '0;
      snap_my <= '0;
      snap_ox <= '0;
      snap_oy <= '0;
      shadow  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap_mx <= mycar_pos_x;
            snap_my <= mycar_pos_y;
            snap_ox <= obstacle_pos_x;
            snap_oy <= obstacle_pos_y;
            shadow  <= '0;
            idx     <= '0;
          end
        end
        SCAN: begin
          shadow <= scan_vec;
          if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; hit changes on the same edge that raises done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      hit     <= '0;
      any_hit <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (last_step) begin
        hit     <= filtered;
        any_hit <= |filtered;
      end
    end
  end

endmodule

// File: tb/tb_collision_scanner.sv
// tb_collision_scanner: directed and randomized scans of collision_scanner
// against a rectangle-geometry reference model.
module tb_collision_scanner;

  localparam int             N       = 5;
  localparam int             W       = 10;
  localparam int             PERSIST = 2;
  localparam logic [N-1:0]   MASK    = 5'b00011;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   mx;
  logic [W-1:0]   my;
  logic [N*W-1:0] px;
  logic [N*W-1:0] py;
  logic           busy;
  logic           done;
  logic [N-1:0]   hit;
  logic           any_hit;

  int checks   = 0;
  int failures = 0;
  int pcnt [N];

  collision_scanner #(
    .N_OBS(N), .W(W), .POLICE_MASK(MASK), .PERSIST(PERSIST)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mycar_pos_x(mx), .mycar_pos_y(my),
    .obstacle_pos_x(px), .obstacle_pos_y(py),
    .busy(busy), .done(done), .hit(hit), .any_hit(any_hit)
  );

  always #5 clk = ~clk;

  // Geometric model: rectangles in plain integers, negatives clamped to 0.
  function automatic logic [N-1:0] raw_model(input int pmx, input int pmy,
                                             input logic [N*W-1:0] qx,
                                             input logic [N*W-1:0] qy);
    logic [N-1:0] res;
    int x, y, l, r, t, b;
    res = '0;
    for (int i = 0; i < N; i++) begin
      x = int'(qx[i*W +: W]);
      y = int'(qy[i*W +: W]);
      if (MASK[i]) begin
        l = x + 5;  r = x + 64 - 5; t = y - 100;      b = y;
      end else begin
        l = x + 15; r = x + 60 - 5; t = y + 10 - 100; b = y - 5;
      end
      if (t < 0) t = 0;
      if (b < 0) b = 0;
      res[i] = (pmx + 15 <= r) && (l <= pmx + 55) && (pmy + 10 <= b) && (t <= pmy + 95);
    end
    return res;
  endfunction

  // Apply one committed scan to the expected hit vector.
  function automatic logic [N-1:0] commit_model(input logic [N-1:0] raw);
    logic [N-1:0] res;
    res = raw;
`ifdef COLLIDE_PERSIST_EN
    for (int i = 0; i < N; i++) begin
      if (raw[i]) pcnt[i] = (pcnt[i] >= PERSIST) ? PERSIST : pcnt[i] + 1;
      else pcnt[i] = 0;
      res[i] = (pcnt[i] == PERSIST);
    end
`endif
    return res;
  endfunction

  function automatic void reset_model();
    for (int i = 0; i < N; i++) pcnt[i] = 0;
  endfunction

  function automatic logic [N*W-1:0] place(input logic [N*W-1:0] v, input int i, input int val);
    logic [N*W-1:0] res;
    res = v;
    res[i*W +: W] = W'(val);
    return res;
  endfunction

  // Run one scan starting at the earliest accepted cycle; lat=-1 on timeout.
  task automatic do_scan(input int smx, input int smy,
                         input logic [N*W-1:0] sx, input logic [N*W-1:0] sy,
                         output logic [N-1:0] exp_h, output int lat,
                         output logic [N-1:0] got_h, output logic got_any,
                         output time t_done);
    @(posedge clk);
    @(negedge clk);
    mx = W'(smx); my = W'(smy); px = sx; py = sy; start = 1'b1;
    lat = -1; got_h = '0; got_any = 1'b0; t_done = 0; exp_h = '0;
    for (int c = 1; c <= 3*N + 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (done) begin
        lat = c; got_h = hit; got_any = any_hit; t_done = $time;
        break;
      end
    end
    start = 1'b0;
    if (lat > 0) exp_h = commit_model(raw_model(smx, smy, sx, sy));
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mx = '0; my = '0; px = '0; py = '0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hit !== '0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit); end
    checks++; if (any_hit !== 1'b0) begin failures++; $display("FAIL reset_any got=%b exp=0", any_hit); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    logic [N-1:0] e, g; logic a; int lat; time t;
    do_scan(200, 300, place('0, 2, 210), place('0, 2, 350), e, lat, g, a, t);
    checks++; if (lat !== N + 1) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, N + 1); end
    checks++; if (g !== e) begin failures++; $display("FAIL basic_hit got=%b exp=%b", g, e); end
    checks++; if (a !== |e) begin failures++; $display("FAIL basic_any got=%b exp=%b", a, |e); end
  endtask

  task automatic test_touch();
    logic [N-1:0] e, g; logic a; int lat; time t;
    do_scan(200, 300, place('0, 0, 156), place('0, 0, 350), e, lat, g, a, t);
    checks++; if (g !== e) begin failures++; $display("FAIL touch_156 got=%b exp=%b", g, e); end
    do_scan(200, 300, place('0, 0, 155), place('0, 0, 350), e, lat, g, a, t);
    checks++; if (g !== e) begin failures++; $display("FAIL touch_155 got=%b exp=%b", g, e); end
    checks++; if (a !== |e) begin failures++; $display("FAIL touch_any got=%b exp=%b", a, |e); end
  endtask

  task automatic test_saturate();
    logic [N-1:0] e, g; logic a; int lat; time t;
    do_scan(200, 0, place('0, 3, 200), place('0, 3, 50), e, lat, g, a, t);
    checks++; if (g !== e) begin failures++; $display("FAIL sat_top got=%b exp=%b", g, e); end
    do_scan(200, 0, place('0, 3, 200), place('0, 3, 3), e, lat, g, a, t);
    checks++; if (g !== e) begin failures++; $display("FAIL sat_bottom got=%b exp=%b", g, e); end
  endtask

  task automatic test_ignore_start();
    logic [N*W-1:0] qx, qy; logic [N-1:0] e, g; int ndone, lat;
    qx = place('0, 2, 210); qy = place('0, 2, 350);
    @(posedge clk); @(negedge clk);
    mx = 10'd200; my = 10'd300; px = qx; py = qy; start = 1'b1;
    ndone = 0; lat = -1; g = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = c; g = hit; end
      end
      start = (c == 2) || (c == 6);
      if (c == 3) begin
        mx = 10'd500; my = 10'd500;
        px = place(place('0, 4, 490), 2, 900);
        py = place(place('0, 4, 560), 2, 100);
      end
    end
    start = 1'b0;
    e = commit_model(raw_model(200, 300, qx, qy));
    checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++; if (lat !== N + 1) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, N + 1); end
    checks++; if (g !== e) begin failures++; $display("FAIL ignore_snapshot got=%b exp=%b", g, e); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] e, g; logic a; int lat, nd; time t;
    do_scan(200, 300, place('0, 2, 210), place('0, 2, 350), e, lat, g, a, t);
    do_scan(200, 300, place('0, 2, 210), place('0, 2, 350), e, lat, g, a, t);
    @(posedge clk); @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
    end
    rst = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (hit !== '0) begin failures++; $display("FAIL midrst_hit got=%b exp=0", hit); end
    checks++; if (any_hit !== 1'b0) begin failures++; $display("FAIL midrst_any got=%b exp=0", any_hit); end
    @(negedge clk); rst = 1'b0; reset_model();
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || busy || hit !== '0) nd++;
    end
    checks++; if (nd !== 0) begin failures++; $display("FAIL midrst_quiet got=%0d exp=0", nd); end
    do_scan(200, 300, place('0, 2, 210), place('0, 2, 350), e, lat, g, a, t);
    checks++; if (lat !== N + 1) begin failures++; $display("FAIL midrst_rescan_latency got=%0d exp=%0d", lat, N + 1); end
    checks++; if (g !== e) begin failures++; $display("FAIL midrst_rescan_hit got=%b exp=%b", g, e); end
  endtask

  task automatic test_random();
    logic [N-1:0] e, g; logic a; int lat, smx, smy, v; logic [N*W-1:0] qx, qy; time t;
    for (int k = 0; k < 30; k++) begin
      smx = int'($urandom_range(0, 800));
      smy = int'($urandom_range(0, 800));
      qx = '0; qy = '0;
      for (int i = 0; i < N; i++) begin
        v = smx + int'($urandom_range(0, 160)) - 80;
        if (v < 0) v = 0; if (v > 1023) v = 1023;
        qx = place(qx, i, v);
        v = smy + int'($urandom_range(0, 240)) - 60;
        if (v < 0) v = 0; if (v > 1023) v = 1023;
        qy = place(qy, i, v);
      end
      do_scan(smx, smy, qx, qy, e, lat, g, a, t);
      checks++; if (lat !== N + 1) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", k, lat, N + 1); end
      checks++; if (g !== e) begin failures++; $display("FAIL rand%0d_hit got=%b exp=%b", k, g, e); end
      checks++; if (a !== |e) begin failures++; $display("FAIL rand%0d_any got=%b exp=%b", k, a, |e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] e, g; logic a; int lat; time t_prev, t;
    do_scan(200, 300, place('0, 2, 210), place('0, 2, 350), e, lat, g, a, t_prev);
    for (int k = 0; k < 2; k++) begin
      do_scan(200, 300, place('0, 1, 180), place('0, 1, 320), e, lat, g, a, t);
      checks++; if (t - t_prev !== (N + 2) * 10) begin failures++; $display("FAIL b2b%0d_period got=%0t exp=%0d", k, t - t_prev, (N + 2) * 10); end
      checks++; if (g !== e) begin failures++; $display("FAIL b2b%0d_hit got=%b exp=%b", k, g, e); end
      t_prev = t;
    end
  endtask

`ifdef COLLIDE_PERSIST_EN
  task automatic test_persist();
    logic [N-1:0] e, g; logic a; int lat; time t;
    logic exp_seq [5];
    logic ovl_seq [5];
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b0; exp_seq[4] = 1'b1;
    ovl_seq[0] = 1'b1; ovl_seq[1] = 1'b1; ovl_seq[2] = 1'b0; ovl_seq[3] = 1'b1; ovl_seq[4] = 1'b1;
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; reset_model();
    for (int k = 0; k < 5; k++) begin
      do_scan(200, 300, place('0, 2, ovl_seq[k] ? 210 : 700), place('0, 2, 350), e, lat, g, a, t);
      checks++; if (g[2] !== exp_seq[k]) begin failures++; $display("FAIL persist%0d_hit2 got=%b exp=%b", k, g[2], exp_seq[k]); end
      checks++; if (g !== e) begin failures++; $display("FAIL persist%0d_vec got=%b exp=%b", k, g, e); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_touch();
    test_saturate();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef COLLIDE_PERSIST_EN
    test_persist();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/collision_scanner.md
# collision_scanner

Frame-rate collision detector for the road game, generalised to `N_OBS` obstacles of mixed sprite kinds. A per-frame `start` pulse snapshots the player car and obstacle positions. The block then checks one obstacle per clock through a single shared box-overlap comparator and commits a stable per-obstacle hit vector with a one-cycle `done` pulse. It sits between the obstacle position generator and the game-state controller.

## Interface
- `N_OBS`, 5: obstacle count, 1..16
- `W`, 10: coordinate width, pixels
- `POLICE_MASK`, 5'b00011: bit i set means obstacle i uses police geometry, clear means car geometry; width `N_OBS`
- `PERSIST`, 2: consecutive overlapping scans required before a hit is reported (only used with `COLLIDE_PERSIST_EN`), 1..3
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, asynchronous, active-high
- `start`  in  1  one-cycle frame strobe; ignored unless idle
- `mycar_pos_x`, `mycar_pos_y`  in  W each  player sprite top-left
- `obstacle_pos_x`  in  N_OBS*W  packed; obstacle i at [i*W +: W]
- `obstacle_pos_y`  in  N_OBS*W  packed; the sprite's bottom y
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse; `hit` updated this cycle
- `hit`  out  N_OBS  per-obstacle collision, stable between `done` pulses
- `any_hit`  out  1  OR of `hit`, registered

## Operation
- Geometry in pixels:
  - Car sprite: 60x100. Offsets: left 15, right 5, front 10, bottom 5.
  - Police sprite: 64x100. Offsets: left 5, right 5.
- Player box:
  - x from `mx+15` to `mx+55`
  - y from `my+10` to `my+95`
- Police obstacle box:
  - x from `x+5` to `x+59`
  - top `sat(y-100)`; bottom `y`
- Car obstacle box:
  - x from `x+15` to `x+55`
  - top `sat(y+10-100)`; bottom `sat(y-5)`
- `sat()` clamps negative results to 0.
- All edge arithmetic is done in W+2 bits, so there is no wrap-around. Right edges are not clipped.
- Overlap is inclusive: `aL<=bR && bL<=aR && aT<=bB && bT<=aB`. Touching edges count as a hit. Any intersection counts, including full containment in either direction.
- FSM states:
  - IDLE: on `start`, snapshot all position inputs into registers, clear the shadow vector, set idx=0, go to SCAN.
  - SCAN: compare snapshot obstacle idx with the player and write the result into shadow[idx]. At idx=N_OBS-1 go to COMMIT, otherwise idx+1.
  - COMMIT: `hit`<=filtered shadow, `any_hit`<=|filtered shadow, `done`=1, go to IDLE.
- Input changes after the snapshot do not affect the current scan.
- `start` in SCAN or COMMIT is dropped; it is not queued.

## Timing
- `start` sampled high in IDLE at edge t:
  - SCAN occupies cycles t+1..t+N_OBS.
  - COMMIT and `done` fall on cycle t+N_OBS+1.
  - Latency is N_OBS+1 cycles; default 6.
- `busy` is high in SCAN and COMMIT, low in IDLE.
- The earliest next accepted `start` is the cycle after `done`. Throughput is one scan per N_OBS+2 cycles.
- Reset values: `busy`=0, `done`=0, `hit`=0, `any_hit`=0, state IDLE, idx=0, persistence counters 0.
- Reset mid-scan aborts the scan. No `done` is produced, and `hit` stays 0 until the next completed scan.
- `start` coincident with `rst`: reset wins.

## Configuration
- `COLLIDE_PERSIST_EN` defined:
  - Each obstacle has a 2-bit saturating counter, updated only at COMMIT: +1 on overlap (saturating at `PERSIST`), cleared on a miss.
  - hit[i] = (counter[i]==`PERSIST`) after the update.
  - This filters single-frame glancing contacts.
- Not defined: filtered shadow = raw shadow, so `hit` reflects the current scan only. No counters exist.

## Structure
- Package `collision_pkg`:
  - geometry localparams (car/police width, height, offsets)
  - FSM state enum {IDLE, SCAN, COMMIT}
  - box struct {left, right, top, bottom} at W+2 bits
  - `sat_sub` function
- Sub-module `box_overlap`: combinational, two box inputs, one overlap output. It is instantiated once and time-shared across obstacles.
- Edge computation of the selected obstacle is muxed by idx and `POLICE_MASK[idx]`.

## Test plan
- Player (200,300); obstacle 2 (car) at (210,350); others at (0,0) with y=0 -> `done` 6 cycles after `start`, `hit`=5'b00100, `any_hit`=1.
- Player (200,300); obstacle 0 (police) x=156, y=350 gives right edge 215, touching -> `hit[0]`=1. Repeat with x=155 -> `hit[0]`=0.
- Player (200,0); obstacle 3 (car) at (200,50), top saturates to 0 -> `hit[3]`=1. Obstacle y=3: bottom saturates to 0, below player front 10 -> `hit[3]`=0.
- `start` pulsed again at cycles t+2 and t+6 of a scan -> both ignored, exactly one `done`. Position inputs changed at t+3 -> result matches the snapshot.
- `rst` asserted at t+3 mid-scan -> `busy`, `done`, `hit` all 0 immediately. The next `start` yields a full 6-cycle scan.
- With `COLLIDE_PERSIST_EN`, `PERSIST`=2, overlap held -> `hit`=0 after the first `done`, 1 after the second. Insert one non-overlapping scan -> 0, then 0 on the next overlapping scan, then 1.
